oisc8_ram_bridge: RTL and testbench

Downstream consumer of the oisc8 CPU memory port (ram_addr / ram_rd_en / ram_wr_en / ram_wr_data / ram_rd_data). It converts single-cycle CPU read and write strobes into a req/ack handshake toward the external memory controller. Writes are posted through a small FIFO. Reads drain the FIFO first so program order is preserved, and the read result is returned with a valid pulse. A busy output lets the CPU pipeline stall.

---
 rtl/oisc8_ram_bridge_if.sv | 22 ++
 rtl/oisc8_ram_bridge.sv | 123 ++++++++++++
 tb/tb_oisc8_ram_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oisc8_ram_bridge_if.sv
// Memory-controller side of the oisc8 RAM bridge: one request held until a
// single-cycle ack.
interface oisc8_ram_bridge_if #(
    parameter int AWIDTH = 24,
    parameter int DWIDTH = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/oisc8_ram_bridge.sv
// Turns oisc8 single-cycle RAM strobes into a req/ack memory handshake.
// Writes are posted through a FIFO; reads wait for that FIFO to drain.
module oisc8_ram_bridge #(
    parameter int AWIDTH = 24,
    parameter int DWIDTH = 16,
    parameter int WDEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AWIDTH-1:0]  ram_addr,
    input  logic               ram_rd_en,
    input  logic               ram_wr_en,
    input  logic [DWIDTH-1:0]  ram_wr_data,
    output logic [DWIDTH-1:0]  ram_rd_data,
    output logic               ram_rd_valid,
    output logic               busy,
    output logic               drop_err,
    oisc8_ram_bridge_if.master mem
);
    localparam int PW = $clog2(WDEPTH) + 1;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    wr_entry_t         fifo_q [WDEPTH];
    wr_entry_t         head;
    logic [PW-1:0]     wr_ptr, rd_ptr, fifo_cnt;
    logic              fifo_empty, fifo_full;
    logic              push, pop, rd_acc, ack_fire, rd_done;
    logic              rd_pend, req_q;
    logic [AWIDTH-1:0] rd_addr;
    state_t            state, state_nx;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign head       = fifo_q[rd_ptr[PW-2:0]];

    assign busy     = rd_pend | fifo_full;
    assign push     = ram_wr_en & ~busy;
    assign rd_acc   = ram_rd_en & ~busy;
    assign ack_fire = req_q & mem.mem_ack;
    assign pop      = ack_fire && (state == WRITE);
    assign rd_done  = ack_fire && (state == READ);
    assign mem.mem_req = req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Strobes accepted this cycle count, so an idle bridge requests on the next edge.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!fifo_empty || push)    state_nx = WRITE;
                else if (rd_pend || rd_acc) state_nx = READ;
            end
            WRITE: begin
                if (pop) begin
                    if (fifo_cnt > PW'(1) || push) state_nx = WRITE;
                    else if (rd_pend || rd_acc)    state_nx = READ;
                    else                           state_nx = IDLE;
                end
            end
            READ:    if (rd_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state)
            WRITE: begin
                mem.mem_we    = 1'b1;
                mem.mem_addr  = head.addr;
                mem.mem_wdata = head.data;
            end
            READ:    mem.mem_addr = rd_addr;
            default: ;
        endcase
    end

    // req drops for one cycle after every ack so each transfer is a distinct request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_pend      <= 1'b0;
            rd_addr      <= '0;
            req_q        <= 1'b0;
            ram_rd_data  <= '0;
            ram_rd_valid <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (rd_acc) begin
                rd_pend <= 1'b1;
                rd_addr <= ram_addr;
            end else if (rd_done) begin
                rd_pend <= 1'b0;
            end
            req_q        <= (state_nx != IDLE) && !ack_fire;
            ram_rd_valid <= rd_done;
            if (rd_done) ram_rd_data <= mem.mem_rdata;
            if ((ram_rd_en || ram_wr_en) && busy) drop_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr[PW-2:0]] <= '{addr: ram_addr, data: ram_wr_data};
    end
endmodule

// File: tb/tb_oisc8_ram_bridge.sv
// Bench for oisc8_ram_bridge: program-order memory model plus directed scenarios.
module tb_oisc8_ram_bridge;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int WD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ram_addr = '0;
    logic          ram_rd_en = 1'b0;
    logic          ram_wr_en = 1'b0;
    logic [DW-1:0] ram_wr_data = '0;
    logic [DW-1:0] ram_rd_data;
    logic          ram_rd_valid, busy, drop_err;

    oisc8_ram_bridge_if #(.AWIDTH(AW), .DWIDTH(DW)) mem_if ();

    oisc8_ram_bridge #(.AWIDTH(AW), .DWIDTH(DW), .WDEPTH(WD)) dut (
        .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
        .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
        .ram_rd_valid(ram_rd_valid), .busy(busy), .drop_err(drop_err), .mem(mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // memory controller side
    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    int ack_delay = 1;
    bit ack_hold = 0;
    bit stray_ack = 0;
    int ack_cnt = 0;

    // program-order model
    logic [DW-1:0] prog_mem [logic [AW-1:0]];
    op_t           exp_ops [$];
    bit            rd_pend_m = 0, drop_m = 0, valid_due = 0;
    int            wcnt_m = 0;
    logic [DW-1:0] due_data = '0, last_rd_m = '0;
    bit            prev_req = 0;
    bit            cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;

    // per-scenario observation logs
    int            req_rises = 0, valid_cnt = 0;
    bit            busy_seen = 0;
    bit            we_log [$];
    logic [AW-1:0] addr_log [$];
    logic [DW-1:0] wdata_log [$];

    function automatic logic [DW-1:0] dflt(logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_op(bit w, bit r, logic [AW-1:0] a, logic [DW-1:0] d);
        ram_wr_en = w; ram_rd_en = r; ram_addr = a; ram_wr_data = d;
        tick();
        ram_wr_en = 1'b0; ram_rd_en = 1'b0;
    endtask

    task automatic clr_logs();
        req_rises = 0; valid_cnt = 0; busy_seen = 0;
        we_log.delete(); addr_log.delete(); wdata_log.delete();
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while ((exp_ops.size() != 0 || mem_if.mem_req || busy) && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_drain_in_time"}, 64'(n < 300), 64'd1);
        repeat (3) tick();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory controller: acks ack_delay cycles after req rises, stores writes on ack
    initial begin
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = '0;
        forever begin
            tick();
            mem_if.mem_ack = 1'b0;
            if (mem_if.mem_req) begin
                if (ack_cnt >= ack_delay && !ack_hold) begin
                    mem_if.mem_ack = 1'b1;
                    ack_cnt = 0;
                    if (mem_if.mem_we) mem_arr[mem_if.mem_addr] = mem_if.mem_wdata;
                    else mem_if.mem_rdata = mem_arr.exists(mem_if.mem_addr) ?
                                            mem_arr[mem_if.mem_addr] : dflt(mem_if.mem_addr);
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
                if (stray_ack) begin
                    mem_if.mem_ack = 1'b1;
                    mem_if.mem_rdata = 16'hDEAD;
                    stray_ack = 0;
                end
            end
        end
    end

    // compare process: outputs at negedge vs model, then apply this cycle's events
    initial forever begin
        bit busy_exp;
        op_t op;
        @(negedge clk);
        if (rst) begin
            chk("rst_mem_req", mem_if.mem_req, 0);
            chk("rst_rd_valid", ram_rd_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_drop_err", drop_err, 0);
            chk("rst_rd_data", ram_rd_data, 0);
            chk("rst_mem_we", mem_if.mem_we, 0);
            chk("rst_mem_addr", mem_if.mem_addr, 0);
            chk("rst_mem_wdata", mem_if.mem_wdata, 0);
            exp_ops.delete();
            rd_pend_m = 0; wcnt_m = 0; drop_m = 0; valid_due = 0;
            last_rd_m = '0; prev_req = 0;
            prog_mem = mem_arr;
        end else begin
            busy_exp = rd_pend_m || (wcnt_m == WD);
            busy_seen |= busy;
            chk("busy", busy, busy_exp);
            chk("drop_err", drop_err, drop_m);
            chk("rd_valid", ram_rd_valid, valid_due);
            if (valid_due) last_rd_m = due_data;
            if (ram_rd_valid) valid_cnt++;
            chk("rd_data", ram_rd_data, last_rd_m);
            valid_due = 0;
            if (mem_if.mem_req) begin
                if (!prev_req) begin
                    req_rises++;
                    cur_we = mem_if.mem_we; cur_addr = mem_if.mem_addr; cur_wdata = mem_if.mem_wdata;
                    we_log.push_back(cur_we); addr_log.push_back(cur_addr); wdata_log.push_back(cur_wdata);
                    if (exp_ops.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_req: got addr %0h expected no request", cur_addr);
                    end else begin
                        chk("req_we", cur_we, exp_ops[0].we);
                        chk("req_addr", cur_addr, exp_ops[0].addr);
                        if (exp_ops[0].we) chk("req_wdata", cur_wdata, exp_ops[0].data);
                    end
                end else begin
                    chk("hold_we", mem_if.mem_we, cur_we);
                    chk("hold_addr", mem_if.mem_addr, cur_addr);
                    chk("hold_wdata", mem_if.mem_wdata, cur_wdata);
                end
                if (mem_if.mem_ack && exp_ops.size() != 0) begin
                    op = exp_ops.pop_front();
                    if (op.we) wcnt_m--;
                    else begin
                        rd_pend_m = 0; valid_due = 1; due_data = op.data;
                    end
                end
            end
            prev_req = mem_if.mem_req;
            if (ram_wr_en || ram_rd_en) begin
                if (busy_exp) drop_m = 1;
                else begin
                    if (ram_wr_en) begin
                        exp_ops.push_back('{we: 1'b1, addr: ram_addr, data: ram_wr_data});
                        prog_mem[ram_addr] = ram_wr_data;
                        wcnt_m++;
                    end
                    if (ram_rd_en) begin
                        exp_ops.push_back('{we: 1'b0, addr: ram_addr,
                            data: prog_mem.exists(ram_addr) ? prog_mem[ram_addr] : dflt(ram_addr)});
                        rd_pend_m = 1;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, busy_cnt, n;
        // reset
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_req", mem_if.mem_req, 0);
        chk("post_rst_drop", drop_err, 0);

        // single write, ack 3 cycles after req
        clr_logs();
        ack_delay = 3;
        cpu_op(1, 0, 24'h000010, 16'hBEEF);
        wait_idle("single_wr");
        chk("single_wr_reqs", req_rises, 1);
        chk("single_wr_we", we_log[0], 1);
        chk("single_wr_addr", addr_log[0], 24'h000010);
        chk("single_wr_data", wdata_log[0], 16'hBEEF);
        chk("single_wr_busy_seen", busy_seen, 0);

        // ack with no request pending is ignored
        clr_logs();
        stray_ack = 1;
        repeat (4) tick();
        chk("stray_ack_valid", valid_cnt, 0);
        chk("stray_ack_reqs", req_rises, 0);

        // write then read of the same address on the next cycle
        clr_logs();
        ack_delay = 2;
        cpu_op(1, 0, 24'h000020, 16'h1234);
        cpu_op(0, 1, 24'h000020, 16'h0000);
        wait_idle("wr_rd");
        chk("wr_rd_data", ram_rd_data, 16'h1234);
        chk("wr_rd_valids", valid_cnt, 1);
        chk("wr_rd_nreq", we_log.size(), 2);
        chk("wr_rd_first_we", we_log[0], 1);
        chk("wr_rd_second_we", we_log[1], 0);

        // FIFO full: four posted writes with ack withheld, fifth is dropped
        clr_logs();
        ack_delay = 1;
        ack_hold = 1;
        for (int i = 0; i < 4; i++) cpu_op(1, 0, 24'h000100 + 24'(i), 16'hA000 + 16'(i));
        chk("full_busy", busy, 1);
        cpu_op(1, 0, 24'h0001FF, 16'hFFFF);
        chk("full_drop_err", drop_err, 1);
        ack_hold = 0;
        wait_idle("full");
        chk("full_busy_after", busy, 0);
        chk("full_nreq", req_rises, 4);
        for (int i = 0; i < 4; i++) chk("full_order", addr_log[i], 24'h000100 + 24'(i));

        // write and read strobed together
        clr_logs();
        cpu_op(1, 1, 24'h0000FF, 16'h00AA);
        wait_idle("both");
        chk("both_data", ram_rd_data, 16'h00AA);
        chk("both_first_we", we_log[0], 1);
        chk("both_second_we", we_log[1], 0);
        chk("both_read_addr", addr_log[1], 24'h0000FF);

        // reset while a read is outstanding
        clr_logs();
        ack_delay = 20;
        cpu_op(0, 1, 24'h000300, 16'h0000);
        repeat (3) tick();
        chk("midrd_req_before", mem_if.mem_req, 1);
        chk("midrd_we_before", mem_if.mem_we, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrd_req_async_drop", mem_if.mem_req, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (25) tick();
        chk("midrd_no_valid", valid_cnt, 0);
        chk("midrd_drop_cleared", drop_err, 0);
        chk("midrd_busy", busy, 0);
        clr_logs();
        ack_delay = 1;
        cpu_op(0, 1, 24'h000044, 16'h0000);
        wait_idle("post_midrd");
        chk("post_midrd_nreq", we_log.size(), 1);
        chk("post_midrd_we", we_log[0], 0);
        chk("post_midrd_data", ram_rd_data, 16'h5A1E);

        // read stalled 10 cycles by the memory
        clr_logs();
        ack_delay = 10;
        k = cyc;
        cpu_op(0, 1, 24'h000020, 16'h0000);
        busy_cnt = 0;
        n = 0;
        while (!ram_rd_valid && n < 50) begin
            if (busy) busy_cnt++;
            tick();
            n++;
        end
        chk("stall_latency", cyc - k, 12);
        chk("stall_busy_cycles", busy_cnt, 11);
        chk("stall_busy_at_valid", busy, 0);
        chk("stall_data", ram_rd_data, 16'h1234);
        chk("stall_nreq", req_rises, 1);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
